// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the button front end and the stack
// controller. The command word is {mod3, mod2, act1, act0}.
package calc_pkg;

  localparam int CMD_W    = 4;
  localparam int NUM_BTNS = 4;

  localparam logic [CMD_W-1:0] CMD_PUSH    = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_POP     = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADD     = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_SUB     = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_TOP     = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_CLR     = 4'b1010;
  localparam logic [CMD_W-1:0] CMD_ADDR_DN = 4'b1101;
  localparam logic [CMD_W-1:0] CMD_ADDR_UP = 4'b1110;

  // An event fires only when an action button (bits [1:0]) rises.
  function automatic logic action_rise(input logic [NUM_BTNS-1:0] cur,
                                       input logic [NUM_BTNS-1:0] nxt);
    return |(nxt[1:0] & ~cur[1:0]);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- 2-flop synchroniser followed by a
// counter debounce. The stable level only flips after the synchronised
// input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   btn          raw asynchronous button level
//   stable       debounced level (registered)
//   stable_next  value stable takes at the coming edge (lets the parent
//                react in the same cycle the level flips)
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic stable,
  output logic stable_next
);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  assign flip        = (sync[1] != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign stable_next = flip ? sync[1] : stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync   <= {sync[0], btn};
      stable <= stable_next;
      // Any agreement restarts the count, so a short glitch never flips.
      if (sync[1] == stable || flip) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_cmd_encoder.sv
// btn_cmd_encoder: debounces the four push-buttons, turns each rising edge
// of an action button (bits [1:0]) into a 4-bit command that also carries
// the modifier levels (bits [3:2]), and holds it in a one-entry buffer
// with a valid/ready handshake.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   btns         raw buttons: [1:0] action, [3:2] modifier
//   cmd          buffered command {mod3, mod2, act1, act0}
//   cmd_valid    cmd holds an unconsumed command
//   cmd_ready    consumer accepts cmd this cycle
//   stable_btns  debounced button levels
//   overrun      sticky: a command was dropped on a full buffer
//   ovr_clr      clears overrun (a coincident drop wins)
module btn_cmd_encoder
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btns,
  output logic [CMD_W-1:0]    cmd,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [NUM_BTNS-1:0] stable_btns,
  output logic                overrun,
  input  logic                ovr_clr
);

  logic [NUM_BTNS-1:0] stable_next;
  logic                evt, xfer, drop;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn        (btns[i]),
      .stable     (stable_btns[i]),
      .stable_next(stable_next[i])
    );
  end

  // Event uses the levels that land this edge, so modifiers pressed earlier
  // and an action already held are both captured in the command word.
  assign evt  = action_rise(stable_btns, stable_next);
  assign xfer = cmd_valid && cmd_ready;
  assign drop = evt && cmd_valid && !xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (evt && !drop) begin
        cmd       <= stable_next;
        cmd_valid <= 1'b1;
      end else if (xfer) begin
        cmd_valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_cmd_encoder.sv
// Bench for btn_cmd_encoder with DEBOUNCE_CYCLES=4. A reference model
// advances on each rising edge and pushes every accepted command into a
// scoreboard queue; a monitor on the falling edge pops on each handshake
// and also compares the level outputs against the model.
module tb_btn_cmd_encoder;
  import calc_pkg::*;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btns = '0;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [3:0] stable_btns;
  logic       overrun;
  logic       ovr_clr = 1'b0;

  btn_cmd_encoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btns       (btns),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .stable_btns(stable_btns),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] h1, h2, mst;          // input delay line and debounced level
  int         mrun [4];             // consecutive cycles differing
  bit         m_full, m_ovr;
  logic [3:0] expq [$];

  initial begin
    logic [3:0] sd, nst;
    bit ev, xf, dr;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        h1 = '0; h2 = '0; mst = '0; m_full = 0; m_ovr = 0;
        foreach (mrun[b]) mrun[b] = 0;
        expq.delete();
      end else begin
        sd = h2; h2 = h1; h1 = btns;
        nst = mst;
        for (int b = 0; b < 4; b++) begin
          if (sd[b] != mst[b]) begin
            mrun[b]++;
            if (mrun[b] == DC) begin nst[b] = sd[b]; mrun[b] = 0; end
          end else mrun[b] = 0;
        end
        ev = ((nst[1:0] & ~mst[1:0]) != 2'b00);
        xf = m_full && cmd_ready;
        dr = ev && m_full && !xf;
        if (ev && !dr) begin expq.push_back(nst); m_full = 1; end
        else if (xf) m_full = 0;
        if (dr) m_ovr = 1;
        else if (ovr_clr) m_ovr = 0;
        mst = nst;
      end
    end
  end

  // ---------------- monitor ----------------
  int         acc_cnt = 0;
  logic [3:0] last_acc = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("stable_btns", 32'(stable_btns), 32'(mst));
        check("cmd_valid", 32'(cmd_valid), 32'(m_full));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (cmd_valid && expq.size() != 0) check("cmd_hold", 32'(cmd), 32'(expq[0]));
        if (cmd_valid && cmd_ready) begin
          if (expq.size() == 0) check("spurious_cmd", 32'(cmd_valid), 32'd0);
          else begin
            check("cmd_xfer", 32'(cmd), 32'(expq.pop_front()));
            acc_cnt++;
            last_acc = cmd;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int a0, hold;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_stable", 32'(stable_btns), 32'd0);

    // Clean press and release
    cmd_ready = 1'b1;
    a0 = acc_cnt;
    btns = 4'b0001; tick(20);
    check("clean_count", 32'(acc_cnt - a0), 32'd1);
    check("clean_cmd", 32'(last_acc), 32'(CMD_PUSH));
    a0 = acc_cnt;
    btns = 4'b0000; tick(20);
    check("release_none", 32'(acc_cnt - a0), 32'd0);

    // Glitch shorter than the debounce window
    btns = 4'b0001; tick(DC - 1);
    btns = 4'b0000; tick(12);
    check("glitch_stable", 32'(stable_btns), 32'd0);
    check("glitch_none", 32'(acc_cnt - a0), 32'd0);

    // Modifier held, then action
    btns = 4'b0100; tick(12);
    btns = 4'b0110; tick(12);
    check("mod_count", 32'(acc_cnt - a0), 32'd1);
    check("mod_sub", 32'(last_acc), 32'(CMD_SUB));
    btns = 4'b0000; tick(12);
    a0 = acc_cnt;
    btns = 4'b1000; tick(12);
    check("mod_only_none", 32'(acc_cnt - a0), 32'd0);
    btns = 4'b0000; tick(12);

    // Backpressure and overrun
    cmd_ready = 1'b0;
    btns = 4'b0001; tick(10);
    btns = 4'b0000; tick(10);
    btns = 4'b0010; tick(10);
    check("bp_cmd", 32'(cmd), 32'(CMD_PUSH));
    check("bp_overrun", 32'(overrun), 32'd1);
    btns = 4'b0000; cmd_ready = 1'b1; tick(1);
    check("bp_drain_valid", 32'(cmd_valid), 32'd0);
    check("bp_drain_cmd", 32'(last_acc), 32'(CMD_PUSH));
    check("bp_overrun_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1; tick(1);
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    tick(10);

    // Event arriving in the same cycle as a transfer
    cmd_ready = 1'b0;
    btns = 4'b0001; tick(10);
    btns = 4'b0000; tick(10);
    btns = 4'b0010; tick(DC + 1);
    check("b2b_pre_cmd", 32'(cmd), 32'(CMD_PUSH));
    cmd_ready = 1'b1; tick(1);
    cmd_ready = 1'b0;
    check("b2b_valid", 32'(cmd_valid), 32'd1);
    check("b2b_cmd", 32'(cmd), 32'(CMD_POP));
    check("b2b_overrun", 32'(overrun), 32'd0);
    check("b2b_first", 32'(last_acc), 32'(CMD_PUSH));
    cmd_ready = 1'b1; tick(2);
    btns = 4'b0000; tick(10);

    // Async reset mid-debounce with a command pending
    cmd_ready = 1'b0;
    btns = 4'b0001; tick(10);
    btns = 4'b0011; tick(DC - 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cmd", 32'(cmd), 32'd0);
    check("arst_valid", 32'(cmd_valid), 32'd0);
    check("arst_stable", 32'(stable_btns), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    tick(2);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    a0 = acc_cnt;
    tick(20);
    check("arst_one_event", 32'(acc_cnt - a0), 32'd1);
    check("arst_event_cmd", 32'(last_acc), 32'd3);
    btns = 4'b0000; tick(12);

    // Random phase: levels held for random spans, random backpressure
    hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        btns = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 3 * DC);
      end
      hold--;
      cmd_ready = ($urandom_range(0, 3) != 0);
      ovr_clr   = ($urandom_range(0, 15) == 0);
      tick(1);
    end

    // Drain
    btns = 4'b0000; ovr_clr = 1'b0; cmd_ready = 1'b1;
    tick(20);
    check("drain_empty", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
